sr_latch_driver: RTL and testbench
==================================

# sr_latch_driver

Sequencing driver for a bank of gated SR latches, each with S, R and enable inputs and a Q output. It accepts single-latch write requests over a valid/ready handshake and drives the selected latch's S/R/enable lines with guaranteed setup, pulse and hold phases. It never drives S=R=1. It then samples the latch's Q through a synchronizer and reports done/error. It sits between the lab's control logic and the latch bank, and is the only agent driving latch inputs.

## Interface
- N, 8: number of latches in the bank (2..32).
- SETUP_CYC, 1: cycles S/R are stable before enable rises (>=1).
- PULSE_CYC, 2: cycles enable is high (>=1).
- HOLD_CYC, 1: cycles S/R stay stable after enable falls (>=1).
- IW, $clog2(N): request index width (localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_idx  in  IW  target latch index.
- req_val  in  1  1 = set (S), 0 = reset (R).
- s_out  out  N  per-latch S line.
- r_out  out  N  per-latch R line.
- en_out  out  N  per-latch enable line.
- q_in  in  N  per-latch Q readback (asynchronous to clk).
- done  out  1  one-cycle pulse: request finished.
- err  out  1  valid only with done: readback mismatch or bad index.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - SETUP: S or R high on the target, enable low.
  - PULSE: S or R high, enable high.
  - HOLD: S or R high, enable low.
  - SYNC: all lines low, 2 cycles.
  - CHECK: done=1 for one cycle.
- Handshake: a request is accepted on an edge where req_valid & req_ready. The block latches idx/val; the requester holds its fields only until then.
- Transitions:
  - IDLE -> SETUP on accept, valid idx.
  - IDLE -> CHECK on accept with idx >= N: no latch lines driven, err=1.
  - SETUP -> PULSE after SETUP_CYC cycles; PULSE -> HOLD after PULSE_CYC; HOLD -> SYNC after HOLD_CYC; SYNC -> CHECK after 2; CHECK -> IDLE.
- Drive rules:
  - req_val=1 drives s_out[idx]; req_val=0 drives r_out[idx].
  - s_out & r_out is zero on every bit, every cycle.
  - At most one en_out bit is high, and only in PULSE.
  - Non-target bits are always 0.
- Check: in CHECK, err = (q_sync[idx] != val). q_sync is q_in after a 2-flop synchronizer.
- The phase counter is a down-counter wide enough for max(SETUP_CYC, PULSE_CYC, HOLD_CYC). It reloads on every state entry.

## Timing
- Reset (rst_n=0 at an edge): next cycle state=IDLE, req_ready=1, s_out=r_out=en_out=0, done=0, err=0, synchronizer flops=0.
- Latency, defaults, accept at edge 0:
  - SETUP cycle 1.
  - PULSE cycles 2-3.
  - HOLD cycle 4.
  - SYNC cycles 5-6.
  - CHECK/done cycle 7.
  - req_ready high again at cycle 8.
- General: done = SETUP_CYC + PULSE_CYC + HOLD_CYC + 3 cycles after accept. Bad index: done 1 cycle after accept.
- req_ready is low from the cycle after accept through CHECK inclusive. A request held valid during CHECK is accepted on the first IDLE cycle; throughput is one request per latency+1 cycles.
- Reset mid-operation (any state): lines drop to 0 on the next edge, the in-flight request is discarded, and no done is issued.
- err is 0 whenever done is 0.

## Structure
- Shared package sr_drv_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, SYNC, CHECK);
  - default timing constants (SETUP_CYC_D, PULSE_CYC_D, HOLD_CYC_D);
  - SYNC_STAGES=2.
- One sub-module: sync_2ff, an N-bit two-flop synchronizer for q_in (synchronous active-low reset, clears to 0).
- Output decode (one-hot from the latched idx, gated by state) lives in the top module.

## Test plan
- Set, defaults, behavioural latch model on bank: req idx=3 val=1 -> s_out[3]=1 cycles 1-4, en_out[3]=1 cycles 2-3 only; done at cycle 7 with err=0; model Q[3]=1.
- Reset-write: after the above, req idx=3 val=0 -> r_out[3]=1 cycles 1-4, s_out all 0; done cycle 7, err=0; Q[3]=0.
- Stuck-at fault: model Q[5] tied 0, req idx=5 val=1 -> done with err=1; all en_out bits other than en_out[5] stay 0 throughout.
- Bad index: N=6, req idx=7 -> s_out/r_out/en_out stay 0; done and err high 1 cycle after accept.
- Reset in PULSE: rst_n low at cycle 2 -> all lines 0 next cycle, no done, req_ready=1; a following request completes normally.
- Back-to-back: req_valid held with two requests (idx 0 val 1, idx 1 val 1) -> second accepted at cycle 8, its done at cycle 15; assert s_out & r_out == 0 and $onehot0(en_out) every cycle.

Source files
------------

// File: rtl/sr_drv_pkg.sv
// Shared types and timing defaults for the SR latch bank driver.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    SYNC,
    CHECK
  } state_t;

  localparam int SETUP_CYC_D = 1;
  localparam int PULSE_CYC_D = 2;
  localparam int HOLD_CYC_D  = 1;
  localparam int SYNC_STAGES = 2;

  function automatic int max_cyc(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request/response handshake between the control logic and the latch driver.
interface sr_latch_driver_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_idx;
  logic          req_val;
  logic          done;
  logic          err;

  modport master (
    output req_valid, req_idx, req_val,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_idx, req_val,
    output req_ready, done, err
  );

endinterface

// File: rtl/sr_latch_driver_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous latch Q readback into clk.
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences setup/pulse/hold on one gated SR latch per request, then verifies Q.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int N         = 8,
  parameter int SETUP_CYC = SETUP_CYC_D,
  parameter int PULSE_CYC = PULSE_CYC_D,
  parameter int HOLD_CYC  = HOLD_CYC_D
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_latch_driver_if.slave    req,
  output logic [N-1:0]        s_out,
  output logic [N-1:0]        r_out,
  output logic [N-1:0]        en_out,
  input  logic [N-1:0]        q_in
);

  localparam int IW      = $clog2(N);
  localparam int MAX_CYC = max_cyc(max_cyc(SETUP_CYC, PULSE_CYC),
                                   max_cyc(HOLD_CYC, SYNC_STAGES));
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] SYNC_LD  = CW'(SYNC_STAGES - 1);
  localparam logic [IW:0]   N_W      = (IW + 1)'(N);
  localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx_q, idx_nxt;
  logic          val_q, val_nxt;
  logic          bad_q, bad_nxt;
  logic          accept, req_bad;
  logic          drive_nxt, pulse_nxt;
  logic [N-1:0]  sel_q, sel_nxt;
  logic [N-1:0]  q_sync;

  sync_2ff #(.W(N)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_in),
    .q     (q_sync)
  );

  assign accept  = req.req_valid && (state == IDLE);
  assign req_bad = ({1'b0, req.req_idx} >= N_W);

  // The phase counter reloads on every state entry and saturates at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
    idx_nxt   = idx_q;
    val_nxt   = val_q;
    bad_nxt   = bad_q;
    case (state)
      IDLE: begin
        if (accept) begin
          idx_nxt = req.req_idx;
          val_nxt = req.req_val;
          bad_nxt = req_bad;
          if (req_bad) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = SETUP;
            cnt_nxt   = SETUP_LD;
          end
        end
      end
      SETUP: if (cnt == '0) begin state_nxt = PULSE; cnt_nxt = PULSE_LD; end
      PULSE: if (cnt == '0) begin state_nxt = HOLD;  cnt_nxt = HOLD_LD;  end
      HOLD:  if (cnt == '0) begin state_nxt = SYNC;  cnt_nxt = SYNC_LD;  end
      SYNC:  if (cnt == '0) state_nxt = CHECK;
      CHECK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch lines are registered from next-state so enable never glitches on a state change.
  assign sel_nxt   = ONE << idx_nxt;
  assign drive_nxt = (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == HOLD);
  assign pulse_nxt = (state_nxt == PULSE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      val_q  <= 1'b0;
      bad_q  <= 1'b0;
      s_out  <= '0;
      r_out  <= '0;
      en_out <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx_q  <= idx_nxt;
      val_q  <= val_nxt;
      bad_q  <= bad_nxt;
      s_out  <= (drive_nxt && val_nxt)  ? sel_nxt : '0;
      r_out  <= (drive_nxt && !val_nxt) ? sel_nxt : '0;
      en_out <= pulse_nxt ? sel_nxt : '0;
    end
  end

  assign sel_q         = ONE << idx_q;
  assign req.req_ready = (state == IDLE);
  assign req.done      = (state == CHECK);
  assign req.err       = (state == CHECK) && (bad_q || ((|(q_sync & sel_q)) != val_q));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver driving a behavioural 6-latch bank.
module tb_sr_latch_driver;

  localparam int NB = 6;

  typedef struct {
    logic [2:0] idx;
    logic       val;
    logic       err;
    logic       bad;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] s_out, r_out, en_out, q_in;
  logic [NB-1:0] q_bank = '0;
  logic [NB-1:0] stuck = '0;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   active = 1'b0;
  bit   armed = 1'b0;
  int   act_a = 0;

  exp_t          e;
  int            n, lat;
  logic [NB-1:0] sel, exp_s, exp_r, exp_en;
  bit            drv, pul;

  sr_latch_driver_if #(.N(NB)) bus ();

  sr_latch_driver #(
    .N         (NB),
    .SETUP_CYC (1),
    .PULSE_CYC (2),
    .HOLD_CYC  (1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus),
    .s_out  (s_out),
    .r_out  (r_out),
    .en_out (en_out),
    .q_in   (q_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gated SR latch bank; stuck bits read back as 0.
  always @(s_out or r_out or en_out) begin
    for (int i = 0; i < NB; i++) begin
      if (en_out[i]) begin
        if (s_out[i]) q_bank[i] = 1'b1;
        else if (r_out[i]) q_bank[i] = 1'b0;
      end
    end
  end

  assign q_in = q_bank & ~stuck;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: timing of each request relative to its accept edge, plus bus invariants.
  always @(negedge clk) begin
    if (armed) begin
      check_output("s_and_r_zero", 32'(s_out & r_out), 32'd0);
      check_output("en_onehot0", 32'($onehot0(en_out)), 32'd1);
      if (active && exp_q.size() > 0) begin
        e      = exp_q[0];
        n      = cyc - act_a + 1;
        lat    = e.bad ? 1 : 7;
        sel    = 6'b000001 << e.idx;
        drv    = !e.bad && (n >= 1) && (n <= 4);
        pul    = !e.bad && (n >= 2) && (n <= 3);
        exp_s  = (drv && e.val)  ? sel : '0;
        exp_r  = (drv && !e.val) ? sel : '0;
        exp_en = pul ? sel : '0;
        check_output("s_out", 32'(s_out), 32'(exp_s));
        check_output("r_out", 32'(r_out), 32'(exp_r));
        check_output("en_out", 32'(en_out), 32'(exp_en));
        check_output("busy_ready", 32'(bus.req_ready), 32'd0);
        check_output("done_timing", 32'(bus.done), 32'(n == lat));
        if (bus.done) begin
          check_output("err", 32'(bus.err), 32'(e.err));
          void'(exp_q.pop_front());
          active = 1'b0;
        end else begin
          check_output("err_without_done", 32'(bus.err), 32'd0);
          if (n >= lat) begin
            void'(exp_q.pop_front());
            active = 1'b0;
          end
        end
      end else begin
        check_output("idle_lines", 32'(s_out | r_out | en_out), 32'd0);
        check_output("idle_ready", 32'(bus.req_ready), 32'd1);
        check_output("idle_done", 32'(bus.done), 32'd0);
        check_output("idle_err", 32'(bus.err), 32'd0);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      active = 1'b0;
      armed  = 1'b1;
    end else if (armed && !active && bus.req_valid && bus.req_ready) begin
      active = 1'b1;
      act_a  = cyc + 1;
    end
  end

  task automatic apply_stimulus(input logic [2:0] idx, input logic val, input logic err_exp,
                                input logic bad, input bit hold, output int acc);
    exp_t x;
    bit   got;
    x.idx = idx; x.val = val; x.err = err_exp; x.bad = bad;
    exp_q.push_back(x);
    bus.req_idx   = idx;
    bus.req_val   = val;
    bus.req_valid = 1'b1;
    got = 1'b0;
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ready && rst_n) begin
        @(posedge clk);
        #1;
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    check_output("accepted", 32'(got), 32'd1);
    bus.req_idx = ~idx;
    bus.req_val = ~val;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (!active && exp_q.size() == 0) begin
        idle = 1'b1;
        break;
      end
    end
    check_output("idle_reached", 32'(idle), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a1, a2;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_idx   = '0;
    bus.req_val   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_ready", 32'(bus.req_ready), 32'd1);
    check_output("reset_lines", 32'(s_out | r_out | en_out), 32'd0);

    $display("[TB] set latch 3");
    apply_stimulus(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, a1);
    wait_idle();
    check_output("q3_set", 32'(q_bank[3]), 32'd1);

    $display("[TB] reset latch 3");
    apply_stimulus(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, a1);
    wait_idle();
    check_output("q3_reset", 32'(q_bank[3]), 32'd0);

    $display("[TB] stuck-at-0 on latch 5");
    stuck = 6'b100000;
    apply_stimulus(3'd5, 1'b1, 1'b1, 1'b0, 1'b0, a1);
    wait_idle();
    stuck = '0;

    $display("[TB] bad index 7");
    apply_stimulus(3'd7, 1'b1, 1'b1, 1'b1, 1'b0, a1);
    wait_idle();

    $display("[TB] reset during pulse");
    apply_stimulus(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, a1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("abort_ready", 32'(bus.req_ready), 32'd1);
    check_output("abort_lines", 32'(s_out | r_out | en_out), 32'd0);
    check_output("abort_done", 32'(bus.done), 32'd0);
    apply_stimulus(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, a1);
    wait_idle();
    check_output("q2_after_abort", 32'(q_bank[2]), 32'd0);

    $display("[TB] back-to-back requests");
    apply_stimulus(3'd0, 1'b1, 1'b0, 1'b0, 1'b1, a1);
    apply_stimulus(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, a2);
    check_output("b2b_gap", 32'(a2 - a1), 32'd8);
    wait_idle();
    check_output("q0_q1_set", 32'(q_bank[1:0]), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
